// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, the register address
// type, and the destination-register select used by the upstream mux.
package cpu_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;

   // Two-way destination-register select (in0 when sel=0, in1 when sel=1)
   function automatic reg_addr_t dst_sel(input reg_addr_t in0,
                                         input reg_addr_t in1,
                                         input logic      sel);
      return sel ? in1 : in0;
   endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: 2**ADDR_W x DATA_W, one write port, two combinational
// read ports, register 0 hard-wired to zero, asynchronous active-high reset.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to a
// read port whose address matches the (non-zero) write address.
module reg_file
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   // mem[0] is only ever reset, so it stays zero; reads of r0 are forced
   // to zero anyway so the rule holds independently of storage.
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] ra [2];
   logic [DATA_W-1:0] rd [2];

   assign ra[0] = ra1;
   assign ra[1] = ra2;
   assign rd1   = rd[0];
   assign rd2   = rd[1];

   // Storage: async clear, then decoded writes; the per-register compare
   // keeps an unknown wa from touching anything while we=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (wa == ADDR_W'(i)) begin
               mem[i] <= wd;
            end
         end
      end
   end

   // Both read ports: identical zero-latency read with r0/reset override
   // and optional write forwarding.
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         rd[p] = '0;
         if (!rst && ra[p] != '0) begin
            rd[p] = mem[ra[p]];
`ifdef REG_FILE_BYPASS_EN
            if (we && wa == ra[p]) begin
               rd[p] = wd;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus hand-written
// sequences for reset timing, reset/write collision, bypass and the
// upstream destination mux. Honours REG_FILE_BYPASS_EN for bypass expectations.
module tb_reg_file;
   import cpu_pkg::*;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;

   int errors = 0;
   int checks = 0;

   reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; wa = a; wd = d;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] byp_exp;
      logic        sel;

      // Reset state and writes ignored while rst=1
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd31;
      #2;
      check("reset_rd1", rd1, 32'h0);
      check("reset_rd2", rd2, 32'h0);
      we = 1'b1; wa = 5'd5; wd = 32'hCAFE_F00D;
      @(posedge clk); #1;
      check("write_during_reset", rd1, 32'h0);

      // First write accepted on first edge after rst deasserts
      @(negedge clk);
      rst = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'h44; ra1 = 5'd4;
      @(posedge clk); #1;
      we = 1'b0;
      check("first_write_after_reset", rd1, 32'h44);

      // Directed table: drive at negedge, check after the following edge
      vecs[0] = '{1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd1,  32'h1234_5678, 32'h0};
      vecs[1] = '{1'b1, 5'd1,  32'h0000_ABCD, 5'd31, 5'd1,  32'h1234_5678, 32'h0000_ABCD};
      vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
      vecs[3] = '{1'b0, 5'd7,  32'h55,        5'd7,  5'd31, 32'h0,         32'h1234_5678};
      vecs[4] = '{1'b1, 5'd7,  32'h77,        5'd7,  5'd7,  32'h77,        32'h77};
      vecs[5] = '{1'b0, 5'bxxxxx, 32'hDEAD_0000, 5'd7, 5'd1, 32'h77,       32'h0000_ABCD};
      vecs[6] = '{1'b1, 5'd2,  32'hA5A5_A5A5, 5'd2,  5'd31, 32'hA5A5_A5A5, 32'h1234_5678};
      vecs[7] = '{1'b1, 5'd31, 32'h0,         5'd31, 5'd2,  32'h0,         32'hA5A5_A5A5};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
         ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
         @(posedge clk); #1;
         check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
         check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
      end
      we = 1'b0; wa = '0;

      // Mid-cycle reset pulse clears immediately
      do_write(5'd5, 32'hDEAD_BEEF);
      ra1 = 5'd5; ra2 = 5'd2;
      #1;
      check("pre_pulse_r5", rd1, 32'hDEAD_BEEF);
      check("pre_pulse_r2", rd2, 32'hA5A5_A5A5);
      #1; rst = 1'b1; #1;
      check("async_clear_r5", rd1, 32'h0);
      check("async_clear_r2", rd2, 32'h0);
      rst = 1'b0; #1;
      check("after_pulse_r5", rd1, 32'h0);

      // Reset asserted on the same edge as a write
      do_write(5'd6, 32'h66);
      ra1 = 5'd6; #1;
      check("r6_written", rd1, 32'h66);
      @(negedge clk);
      we = 1'b1; wa = 5'd6; wd = 32'h6666;
      @(posedge clk);
      rst = 1'b1;
      #1;
      check("reset_wins_edge", rd1, 32'h0);
      @(negedge clk);
      rst = 1'b0; we = 1'b0;
      #1;
      check("reset_wins_after", rd1, 32'h0);

      // Bypass: pre-edge value depends on build, post-edge always new
      do_write(5'd3, 32'h11);
      @(negedge clk);
      we = 1'b1; wa = 5'd3; wd = 32'h22; ra1 = 5'd3; ra2 = 5'd3;
      #1;
`ifdef REG_FILE_BYPASS_EN
      byp_exp = 32'h22;
`else
      byp_exp = 32'h11;
`endif
      check("bypass_pre_rd1", rd1, byp_exp);
      check("bypass_pre_rd2", rd2, byp_exp);
      @(posedge clk); #1;
      we = 1'b0;
      check("bypass_post_rd1", rd1, 32'h22);
      @(negedge clk);
      we = 1'b1; wa = 5'd0; wd = 32'h99; ra1 = 5'd0;
      #1;
      check("bypass_r0_override", rd1, 32'h0);
      @(posedge clk); #1;
      we = 1'b0;
      check("r0_after_write", rd1, 32'h0);

      // Upstream destination mux feeding wa
      sel = 1'b0;
      do_write(dst_sel(5'b11100, 5'b11111, sel), 32'hA);
      sel = 1'b1;
      do_write(dst_sel(5'b11100, 5'b11111, sel), 32'hB);
      ra1 = 5'd28; ra2 = 5'd31; #1;
      check("mux_r28", rd1, 32'hA);
      check("mux_r31", rd2, 32'hB);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
